mem_access_stage: RTL

- MIPS pipeline Memory stage. Owns the EX/MEM pipeline register, which is loaded from the Execute stage outputs, and the MEM/WB pipeline register, which feeds Write-Back.
- Drives a variable-latency data-memory request/acknowledge interface and stalls upstream stages while an access is outstanding.
- Resolves branches (PCSrc) and detects misaligned word accesses and bus timeouts.

---
 rtl/mem_access_stage_pkg.sv | 23 ++
 rtl/mem_access_stage_timeout_counter.sv | 18 +
 rtl/mem_access_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared types and constants for the MIPS memory stage.
package mem_access_stage_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  localparam logic [1:0] ALIGN_MASK = 2'b00;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HALT = 2'd2} state_t;
  typedef struct packed {
    logic valid;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic reg_write;
    logic mem_to_reg;
    logic zero;
    logic [REG_W-1:0] rd;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] branch_target;
    logic [DATA_W-1:0] store_data;
  } ex_mem_t;
  function automatic logic misaligned(input logic [DATA_W-1:0] addr);
    return addr[1:0] != ALIGN_MASK;
  endfunction
endpackage

// File: rtl/mem_access_stage_timeout_counter.sv
// mem_timeout_counter: counts cycles an access waits for dmem_ack and flags expiry.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic busy,
  input  logic ack,
  output logic expire
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = start ? 8'd1 : (busy & !ack) ? cnt_q + 8'd1 : 8'd0;
  assign expire = busy & !ack & (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage with EX/MEM and MEM/WB registers, a
// req/ack data-memory port, branch resolution, alignment and timeout checks.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic              zero,
  input  logic [DATA_W-1:0] AddResult,
  input  logic [DATA_W-1:0] ALUReadData2_Out,
  input  logic [REG_W-1:0]  RdOrRt,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              branch,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              align_err,
  output logic              bus_error
);
  ex_mem_t m_q, m_d;
  state_t state_q, state_d;
  logic is_mem, mis, pending, advance, expire;
  logic wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d, align_err_q, align_err_d;
  logic [REG_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  assign is_mem = m_q.mem_read | m_q.mem_write;
  assign mis = is_mem & misaligned(m_q.alu_result);
  assign pending = m_q.valid & is_mem & !mis;
  assign advance = !(pending & !dmem_ack) & (state_q != HALT);
  always_comb
    m_d = advance ? ex_mem_t'{ex_valid, mem_read, mem_write, branch, reg_write, mem_to_reg,
                               zero, RdOrRt, ALUResult, AddResult, ALUReadData2_Out} : m_q;
  mem_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (state_q == IDLE && pending && !dmem_ack),
    .busy   (state_q == WAIT),
    .ack    (dmem_ack),
    .expire (expire)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // ack on the final wait cycle takes priority over the timeout
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && pending && !dmem_ack) state_d = WAIT;
    else if (state_q == WAIT) state_d = dmem_ack ? IDLE : expire ? HALT : WAIT;
  end
  always_comb begin
    dmem_req = pending & (state_q != HALT);
    stall = !advance;
    bus_error = state_q == HALT;
  end
  always_comb begin
    wb_valid_d = advance & m_q.valid;
    wb_reg_write_d = advance & m_q.valid & m_q.reg_write & !mis;
    align_err_d = advance & m_q.valid & mis;
    wb_rd_d = advance ? m_q.rd : wb_rd_q;
    wb_data_d = advance ? (m_q.mem_to_reg ? dmem_rdata : m_q.alu_result) : wb_data_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_q <= '0;
      wb_valid_q <= 1'b0;
      wb_reg_write_q <= 1'b0;
      align_err_q <= 1'b0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
    end else begin
      m_q <= m_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      align_err_q <= align_err_d;
      wb_rd_q <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  assign pc_src = m_q.valid & m_q.branch & m_q.zero;
  assign branch_target = m_q.branch_target;
  assign dmem_we = m_q.mem_write;
  assign dmem_addr = m_q.alu_result;
  assign dmem_wdata = m_q.store_data;
  assign wb_valid = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd = wb_rd_q;
  assign wb_data = wb_data_q;
  assign align_err = align_err_q;
endmodule
